// File: rtl/axi_mem_responder.sv
// -----------------------------------------------------------------------------
// axi_mem_responder
//
// Single-ID AXI4 memory responder used as the downstream memory behind the
// ID-stripping bridge. One write and one read transaction may be in flight at
// a time, each handled by its own FSM. Both FSMs share one word-addressed
// array. FIXED, INCR and WRAP bursts are supported. Byte strobes are
// honoured. Out-of-range beats and the reserved burst type answer SLVERR.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_axi_aw*              write address channel (valid/ready/addr/len/size/burst)
//   s_axi_w*               write data channel (valid/ready/data/strb/last)
//   s_axi_b*               write response channel (valid/ready/resp)
//   s_axi_ar*              read address channel (valid/ready/addr/len/size/burst)
//   s_axi_r*               read data channel (valid/ready/data/resp/last)
// -----------------------------------------------------------------------------
module axi_mem_responder #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [7:0]              s_axi_awlen,
    input  logic [2:0]              s_axi_awsize,
    input  logic [1:0]              s_axi_awburst,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wlast,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [7:0]              s_axi_arlen,
    input  logic [2:0]              s_axi_arsize,
    input  logic [1:0]              s_axi_arburst,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rlast
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(MEM_WORDS);
    // First address bit above the memory; any 1 at or above it is out of range.
    localparam int TOP   = OFF_W + IDX_W;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3:0] LAT_LOAD = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } r_state_e;

    // Address of the beat following 'addr'. WRAP keeps the upper bits of the
    // aligned (len+1)<<size window and lets only the in-window bits roll over.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [7:0]            len,
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] wrap_mask;
        logic [ADDR_WIDTH-1:0] stepped;
        step      = ADDR_ONE << size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_ONE) << size) - ADDR_ONE;
        stepped   = addr + step;
        case (burst)
            2'b01:   next_addr = stepped;
            2'b10:   next_addr = (addr & ~wrap_mask) | (stepped & wrap_mask);
            default: next_addr = addr;   // FIXED and reserved
        endcase
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    logic rdy_en_q;
    logic rdy_en_d;

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [7:0]            aw_len_q, aw_len_d;
    logic [2:0]            aw_size_q, aw_size_d;
    logic [1:0]            aw_burst_q, aw_burst_d;
    logic [8:0]            w_cnt_q, w_cnt_d;
    logic                  w_err_q, w_err_d;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] ar_addr_q, ar_addr_d;
    logic [7:0]            ar_len_q, ar_len_d;
    logic [2:0]            ar_size_q, ar_size_d;
    logic [1:0]            ar_burst_q, ar_burst_d;
    logic [8:0]            r_cnt_q, r_cnt_d;
    logic [3:0]            lat_cnt_q, lat_cnt_d;

    logic             mem_we_s;
    logic [IDX_W-1:0] w_idx_s;
    logic [IDX_W-1:0] r_idx_s;
    logic             w_beat_err_s;
    logic             r_beat_err_s;
    logic             w_last_beat_s;
    logic             r_last_beat_s;

    assign rdy_en_d      = 1'b1;
    assign w_idx_s       = aw_addr_q[TOP-1:OFF_W];
    assign r_idx_s       = ar_addr_q[TOP-1:OFF_W];
    assign w_beat_err_s  = (|aw_addr_q[ADDR_WIDTH-1:TOP]) || (aw_burst_q == 2'b11);
    assign r_beat_err_s  = (|ar_addr_q[ADDR_WIDTH-1:TOP]) || (ar_burst_q == 2'b11);
    assign w_last_beat_s = (w_cnt_q == {1'b0, aw_len_q});
    assign r_last_beat_s = (r_cnt_q == {1'b0, ar_len_q});

    // Ready-enable: holds awready/arready low until the first edge after reset.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdy_en_q <= 1'b0;
        end else begin
            rdy_en_q <= rdy_en_d;
        end
    end

    // Write-channel state and latched burst fields.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_q  <= W_IDLE;
            aw_addr_q  <= {ADDR_WIDTH{1'b0}};
            aw_len_q   <= 8'd0;
            aw_size_q  <= 3'd0;
            aw_burst_q <= 2'd0;
            w_cnt_q    <= 9'd0;
            w_err_q    <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            aw_addr_q  <= aw_addr_d;
            aw_len_q   <= aw_len_d;
            aw_size_q  <= aw_size_d;
            aw_burst_q <= aw_burst_d;
            w_cnt_q    <= w_cnt_d;
            w_err_q    <= w_err_d;
        end
    end

    // Write FSM: next state, beat sequencing and channel outputs.
    always_comb begin
        w_state_d     = w_state_q;
        aw_addr_d     = aw_addr_q;
        aw_len_d      = aw_len_q;
        aw_size_d     = aw_size_q;
        aw_burst_d    = aw_burst_q;
        w_cnt_d       = w_cnt_q;
        w_err_d       = w_err_q;
        mem_we_s      = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        s_axi_bresp   = 2'b00;
        case (w_state_q)
            W_IDLE: begin
                s_axi_awready = rdy_en_q;
                if (s_axi_awvalid && rdy_en_q) begin
                    aw_addr_d  = s_axi_awaddr;
                    aw_len_d   = s_axi_awlen;
                    aw_size_d  = s_axi_awsize;
                    aw_burst_d = s_axi_awburst;
                    w_cnt_d    = 9'd0;
                    w_err_d    = 1'b0;
                    w_state_d  = W_DATA;
                end else begin
                    w_state_d  = W_IDLE;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    // Bad beats are dropped; a wlast that disagrees with the
                    // counter only flags the error, the counter still ends the burst.
                    mem_we_s = !w_beat_err_s;
                    if (w_beat_err_s || (s_axi_wlast != w_last_beat_s)) begin
                        w_err_d = 1'b1;
                    end else begin
                        w_err_d = w_err_q;
                    end
                    if (w_last_beat_s) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d   = w_cnt_q + 9'd1;
                        aw_addr_d = next_addr(aw_addr_q, aw_len_q, aw_size_q, aw_burst_q);
                    end
                end else begin
                    w_state_d = W_DATA;
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                s_axi_bresp  = w_err_q ? 2'b10 : 2'b00;
                if (s_axi_bready) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_state_d = W_RESP;
                end
            end
            default: begin
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Byte-lane write into the shared array; contents are kept across reset.
    always_ff @(posedge aclk) begin
        if (mem_we_s) begin
            for (int b = 0; b < BYTES; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx_s][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Read-channel state, latched burst fields and latency counter.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_q  <= R_IDLE;
            ar_addr_q  <= {ADDR_WIDTH{1'b0}};
            ar_len_q   <= 8'd0;
            ar_size_q  <= 3'd0;
            ar_burst_q <= 2'd0;
            r_cnt_q    <= 9'd0;
            lat_cnt_q  <= 4'd0;
        end else begin
            r_state_q  <= r_state_d;
            ar_addr_q  <= ar_addr_d;
            ar_len_q   <= ar_len_d;
            ar_size_q  <= ar_size_d;
            ar_burst_q <= ar_burst_d;
            r_cnt_q    <= r_cnt_d;
            lat_cnt_q  <= lat_cnt_d;
        end
    end

    // Read FSM: next state, beat sequencing and channel outputs. rdata comes
    // straight from the array, so a same-cycle write is seen one beat later.
    always_comb begin
        r_state_d     = r_state_q;
        ar_addr_d     = ar_addr_q;
        ar_len_d      = ar_len_q;
        ar_size_d     = ar_size_q;
        ar_burst_d    = ar_burst_q;
        r_cnt_d       = r_cnt_q;
        lat_cnt_d     = lat_cnt_q;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        s_axi_rdata   = {DATA_WIDTH{1'b0}};
        s_axi_rresp   = 2'b00;
        s_axi_rlast   = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                s_axi_arready = rdy_en_q;
                if (s_axi_arvalid && rdy_en_q) begin
                    ar_addr_d  = s_axi_araddr;
                    ar_len_d   = s_axi_arlen;
                    ar_size_d  = s_axi_arsize;
                    ar_burst_d = s_axi_arburst;
                    r_cnt_d    = 9'd0;
                    lat_cnt_d  = LAT_LOAD;
                    r_state_d  = (READ_LATENCY == 0) ? R_DATA : R_WAIT;
                end else begin
                    r_state_d  = R_IDLE;
                end
            end
            R_WAIT: begin
                // Loaded with latency-1, so R_WAIT lasts exactly READ_LATENCY cycles.
                if (lat_cnt_q == 4'd0) begin
                    r_state_d = R_DATA;
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                s_axi_rlast  = r_last_beat_s;
                if (r_beat_err_s) begin
                    s_axi_rresp = 2'b10;
                end else begin
                    s_axi_rdata = mem[r_idx_s];
                end
                if (s_axi_rready) begin
                    if (r_last_beat_s) begin
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d   = r_cnt_q + 9'd1;
                        ar_addr_d = next_addr(ar_addr_q, ar_len_q, ar_size_q, ar_burst_q);
                    end
                end else begin
                    r_state_d = R_DATA;
                end
            end
            default: begin
                r_state_d = R_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
module tb_axi_mem_responder;

    localparam int     RL        = 2;
    localparam int     MW        = 1024;
    localparam longint MEM_BYTES = 64'd8192;

    logic        aclk, aresetn;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_wvalid, s_axi_wready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_rvalid, s_axi_rready;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;

    axi_mem_responder #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .MEM_WORDS(MW), .READ_LATENCY(RL)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast)
    );

    // Reference memory and per-transaction scratch storage.
    logic [63:0] model_mem [MW];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    logic [63:0] rd_d [256];
    logic [1:0]  rd_r [256];
    logic        rd_l [256];
    longint      rd_cyc [256];
    longint      w_hs_cyc;
    longint      cyc_cnt;
    int          n_chk;
    int          n_pass;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial cyc_cnt = 0;
    always @(posedge aclk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, checks done %0d", n_chk);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Byte address of beat i, computed from the burst rules directly.
    function automatic longint beat_addr(input longint start, input int len, input int size,
                                         input int burst, input int i);
        longint incr, window, base;
        incr = longint'(1) << size;
        case (burst)
            1: return start + longint'(i) * incr;
            2: begin
                window = longint'(len + 1) * incr;
                base   = start - (start % window);
                return base + ((start - base) + longint'(i) * incr) % window;
            end
            default: return start;
        endcase
    endfunction

    function automatic logic [1:0] model_write(input longint addr, input int len, input int size,
                                               input int burst, input int last_mode);
        bit     err;
        longint a;
        err = 1'b0;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            if (burst == 3 || a >= MEM_BYTES) begin
                err = 1'b1;
            end else begin
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) model_mem[int'(a / 8)][b*8 +: 8] = wd[i][b*8 +: 8];
            end
        end
        if (last_mode != 0 && len > 0) err = 1'b1;
        return err ? 2'b10 : 2'b00;
    endfunction

    // last_mode 0: wlast on the final beat; 1: wlast on the first beat only.
    task automatic do_write(input longint addr, input int len, input int size, input int burst,
                            input int last_mode, input int wdelay, output logic [1:0] resp);
        bit ok;
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr[31:0]; s_axi_awlen = 8'(len);
        s_axi_awsize = 3'(size); s_axi_awburst = 2'(burst);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge aclk);
            if (s_axi_awready) begin ok = 1'b1; break; end
        end
        chk("aw_handshake", 64'(ok), 64'd1);
        @(posedge aclk); #1;
        s_axi_awvalid = 1'b0;
        for (int d = 0; d < wdelay; d++) begin @(posedge aclk); #1; end
        for (int i = 0; i <= len; i++) begin
            s_axi_wvalid = 1'b1; s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = (last_mode == 0) ? (i == len) : (i == 0);
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge aclk);
                if (s_axi_wready) begin ok = 1'b1; break; end
            end
            if (!ok) begin chk("w_handshake", 64'(ok), 64'd1); break; end
            w_hs_cyc = cyc_cnt;
            @(posedge aclk); #1;
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
        ok = 1'b0; resp = 2'b11;
        for (int t = 0; t < 100; t++) begin
            @(negedge aclk);
            if (s_axi_bvalid) begin ok = 1'b1; resp = s_axi_bresp; break; end
        end
        chk("b_handshake", 64'(ok), 64'd1);
        @(posedge aclk); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input longint addr, input int len, input int size, input int burst,
                           input bit toggle, output int lat, output int nb);
        bit          ok, have_prev;
        logic [63:0] prev_d;
        logic [1:0]  prev_r;
        logic        prev_l;
        int          cyc;
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b1; s_axi_araddr = addr[31:0]; s_axi_arlen = 8'(len);
        s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge aclk);
            if (s_axi_arready) begin ok = 1'b1; break; end
        end
        chk("ar_handshake", 64'(ok), 64'd1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        s_axi_rready = !toggle;
        nb = 0; lat = 0; cyc = 0; have_prev = 1'b0;
        prev_d = 64'd0; prev_r = 2'd0; prev_l = 1'b0;
        while (ok && nb <= len && cyc < 600) begin
            @(negedge aclk);
            cyc++;
            if (s_axi_rvalid) begin
                if (lat == 0) lat = cyc;
                if (have_prev) begin
                    chk("r_hold_data", s_axi_rdata, prev_d);
                    chk("r_hold_resp", 64'(s_axi_rresp), 64'(prev_r));
                    chk("r_hold_last", 64'(s_axi_rlast), 64'(prev_l));
                end
                if (s_axi_rready) begin
                    rd_d[nb] = s_axi_rdata; rd_r[nb] = s_axi_rresp;
                    rd_l[nb] = s_axi_rlast; rd_cyc[nb] = cyc_cnt;
                    nb++;
                    have_prev = 1'b0;
                end else begin
                    have_prev = 1'b1;
                    prev_d = s_axi_rdata; prev_r = s_axi_rresp; prev_l = s_axi_rlast;
                end
            end
            @(posedge aclk); #1;
            s_axi_rready = toggle ? !s_axi_rready : 1'b1;
        end
        s_axi_rready = 1'b0;
    endtask

    task automatic check_read(input longint addr, input int len, input int size, input int burst,
                              input int nb);
        longint a;
        bit     err;
        chk("rd_beats", 64'(nb), 64'(len + 1));
        for (int i = 0; i < nb; i++) begin
            a = beat_addr(addr, len, size, burst, i);
            err = (burst == 3) || (a >= MEM_BYTES);
            chk("rdata", rd_d[i], err ? 64'd0 : model_mem[int'(a / 8)]);
            chk("rresp", 64'(rd_r[i]), err ? 64'd2 : 64'd0);
            chk("rlast", 64'(rd_l[i]), 64'(i == len));
        end
    endtask

    task automatic wr(input longint addr, input int len, input int size, input int burst,
                      input int last_mode);
        logic [1:0] got, exp;
        do_write(addr, len, size, burst, last_mode, 0, got);
        exp = model_write(addr, len, size, burst, last_mode);
        chk("bresp", 64'(got), 64'(exp));
    endtask

    task automatic rd(input longint addr, input int len, input int size, input int burst,
                      input bit toggle);
        int lat, nb;
        do_read(addr, len, size, burst, toggle, lat, nb);
        check_read(addr, len, size, burst, nb);
    endtask

    task automatic reset_release();
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rel_awready_low", 64'(s_axi_awready), 64'd0);
        @(negedge aclk);
        chk("rel_awready", 64'(s_axi_awready), 64'd1);
        chk("rel_arready", 64'(s_axi_arready), 64'd1);
    endtask

    initial begin
        logic [63:0] exp_wrap [4];
        logic [63:0] old_v, new_v;
        logic [1:0]  b_got, b_exp;
        int          lat, nb, len, size, burst, lmode;
        longint      addr;
        bit          hit, ok;

        n_chk = 0; n_pass = 0; w_hs_cyc = 0;
        aresetn = 1'b0;
        s_axi_awvalid = 1'b0; s_axi_awaddr = 32'd0; s_axi_awlen = 8'd0;
        s_axi_awsize = 3'd0; s_axi_awburst = 2'd0;
        s_axi_wvalid = 1'b0; s_axi_wdata = 64'd0; s_axi_wstrb = 8'd0; s_axi_wlast = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arvalid = 1'b0; s_axi_araddr = 32'd0; s_axi_arlen = 8'd0;
        s_axi_arsize = 3'd0; s_axi_arburst = 2'd0; s_axi_rready = 1'b0;

        // Reset values.
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_awready", 64'(s_axi_awready), 64'd0);
        chk("rst_arready", 64'(s_axi_arready), 64'd0);
        chk("rst_wready", 64'(s_axi_wready), 64'd0);
        chk("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
        chk("rst_bresp", 64'(s_axi_bresp), 64'd0);
        chk("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
        chk("rst_rdata", s_axi_rdata, 64'd0);
        chk("rst_rresp", 64'(s_axi_rresp), 64'd0);
        chk("rst_rlast", 64'(s_axi_rlast), 64'd0);
        reset_release();

        // W before AW is back-pressured.
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            chk("w_before_aw", 64'(s_axi_wready), 64'd0);
        end
        @(posedge aclk); #1;
        s_axi_wvalid = 1'b0;

        // Fill the whole array with known data (also exercises awlen=255).
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
            wr(longint'(blk) * 2048, 255, 3, 1, 0);
        end

        // INCR write/read with latency check.
        for (int i = 0; i < 4; i++) begin wd[i] = 64'(i + 1); ws[i] = 8'hFF; end
        wr(64'h40, 3, 3, 1, 0);
        do_read(64'h40, 3, 3, 1, 1'b0, lat, nb);
        chk("rd_latency", 64'(lat), 64'(1 + RL));
        check_read(64'h40, 3, 3, 1, nb);
        for (int i = 0; i < 4; i++) chk("incr_data", rd_d[i], 64'(i + 1));

        // WRAP write, INCR read-back.
        wr(64'h10, 3, 3, 2, 0);
        rd(64'h0, 3, 3, 1, 1'b0);
        exp_wrap[0] = 64'd3; exp_wrap[1] = 64'd4; exp_wrap[2] = 64'd1; exp_wrap[3] = 64'd2;
        for (int i = 0; i < 4; i++) chk("wrap_order", rd_d[i], exp_wrap[i]);

        // Strobes and R backpressure.
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        wr(64'h0, 0, 3, 1, 0);
        wd[0] = 64'h0; ws[0] = 8'h0F;
        wr(64'h0, 0, 3, 1, 0);
        rd(64'h0, 3, 3, 1, 1'b1);
        chk("strobe_word", rd_d[0], 64'hFFFF_FFFF_0000_0000);

        // Error responses.
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        wr(64'h2000, 0, 3, 1, 0);
        rd(64'h0, 0, 3, 1, 1'b0);
        wd[0] = 64'hAAAA; wd[1] = 64'hBBBB; ws[0] = 8'hFF; ws[1] = 8'hFF;
        wr(64'h80, 1, 3, 1, 1);
        rd(64'h80, 1, 3, 1, 1'b0);
        rd(64'h2000, 0, 3, 1, 1'b0);
        rd(64'h100, 1, 3, 3, 1'b0);

        // Concurrent AW/AR on one word: collision beat returns old data.
        old_v = model_mem[64];
        wd[0] = ~old_v; ws[0] = 8'hFF;
        fork
            do_write(64'h200, 0, 3, 1, 0, 4, b_got);
            do_read(64'h200, 7, 3, 0, 1'b0, lat, nb);
        join
        b_exp = model_write(64'h200, 0, 3, 1, 0);
        chk("cc_bresp", 64'(b_got), 64'(b_exp));
        new_v = model_mem[64];
        chk("cc_beats", 64'(nb), 64'd8);
        hit = 1'b0;
        for (int i = 0; i < nb; i++) begin
            chk("cc_rdata", rd_d[i], (rd_cyc[i] <= w_hs_cyc) ? old_v : new_v);
            if (rd_cyc[i] == w_hs_cyc) hit = 1'b1;
        end
        chk("cc_collision", 64'(hit), 64'd1);

        // Reset in the middle of a read burst.
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b1; s_axi_araddr = 32'h400; s_axi_arlen = 8'd7;
        s_axi_arsize = 3'd3; s_axi_arburst = 2'd1; s_axi_rready = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(negedge aclk);
            if (s_axi_arready) begin ok = 1'b1; break; end
        end
        chk("mr_ar_handshake", 64'(ok), 64'd1);
        @(posedge aclk); #1;
        s_axi_arvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        chk("mr_rvalid_before", 64'(s_axi_rvalid), 64'd1);
        aresetn = 1'b0;
        #1;
        chk("mr_rvalid_in_rst", 64'(s_axi_rvalid), 64'd0);
        chk("mr_arready_in_rst", 64'(s_axi_arready), 64'd0);
        s_axi_rready = 1'b0;
        reset_release();
        rd(64'h400, 7, 3, 1, 1'b0);

        // Randomized bursts against the reference memory.
        for (int it = 0; it < 40; it++) begin
            burst = $urandom_range(0, 2);
            size  = $urandom_range(0, 3);
            len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
            addr  = longint'($urandom_range(0, 1087)) * 8 + longint'(($urandom_range(0, 7) >> size) << size);
            for (int i = 0; i <= len; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            lmode = ($urandom_range(0, 9) == 0 && len > 0) ? 1 : 0;
            wr(addr, len, size, burst, lmode);
            if ($urandom_range(0, 1) == 1) begin
                burst = $urandom_range(0, 2);
                size  = $urandom_range(0, 3);
                len   = (burst == 2) ? ((1 << $urandom_range(1, 4)) - 1) : $urandom_range(0, 15);
                addr  = longint'($urandom_range(0, 1087)) * 8 + longint'(($urandom_range(0, 7) >> size) << size);
            end
            if ($urandom_range(0, 9) == 0) burst = 3;
            rd(addr, len, size, burst, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
Name: axi_mem_responder

Overview:
AXI4 memory responder (slave) for the ID-free master side of the AXI ID-stripping bridge, used as the downstream memory model in simulation benches. It accepts single-ID AW/W/AR traffic and returns B/R responses strictly in order, with one outstanding transaction per direction. It supports FIXED, INCR and WRAP bursts, byte strobes, a configurable read latency and SLVERR for out-of-range addresses. Read and write paths run independently and share one word-addressed memory array.

Parameters:
ADDR_WIDTH, 32, address width in bits.
DATA_WIDTH, 64, data width in bits (power of two, >=8).
MEM_WORDS, 1024, memory depth in DATA_WIDTH words (power of two).
READ_LATENCY, 2, idle cycles between AR handshake and first R beat (0..15).

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_axi_awvalid/awready  in/out  1  AW handshake
s_axi_awaddr  in  ADDR_WIDTH  write start byte address
s_axi_awlen/awsize/awburst  in  8/3/2  burst length-1, beat size, burst type
s_axi_wvalid/wready  in/out  1  W handshake
s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write beat
s_axi_bvalid/bready  out/in  1  B handshake
s_axi_bresp  out  2  write response
s_axi_arvalid/arready  in/out  1  AR handshake
s_axi_araddr  in  ADDR_WIDTH  read start byte address
s_axi_arlen/arsize/arburst  in  8/3/2  as AW
s_axi_rvalid/rready  out/in  1  R handshake
s_axi_rdata/rresp/rlast  out  DATA_WIDTH/2/1  read beat
There are no ID ports. lock/cache/prot/qos/region are not present and are left unconnected by the integrator.

Behaviour:
- Reset (aresetn low, async): both FSMs go to IDLE. awready, wready, bvalid, arready and rvalid are 0; bresp=0, rresp=0, rlast=0, rdata=0. Memory contents are not cleared. awready/arready first go to 1 in the first cycle after reset release (registered ready-enable flop). Reset mid-burst abandons the burst with no response.
- Address map: BYTES=DATA_WIDTH/8. Word index = addr[log2(MEM_WORDS)+log2(BYTES)-1 : log2(BYTES)]. A beat is out of range if its address >= MEM_WORDS*BYTES.
- Address sequencing (per beat, after each handshake):
  - FIXED: address unchanged.
  - INCR: addr += 1<<size.
  - WRAP: addr += 1<<size, wrapping within the aligned (len+1)<<size window.
  - burst=2'b11 (reserved): treated as FIXED, and every beat is flagged SLVERR.
  - Data lanes are never shifted: narrow beats use wstrb as given, and reads return the full word.
- Write FSM:
  - W_IDLE (awready=1): AW handshake latches addr/len/size/burst, clears beat counter and error flag -> W_DATA.
  - W_DATA (wready=1): each W handshake writes bytes where wstrb=1 to the in-range word at the clock edge. An out-of-range beat is dropped and sets the error flag. The beat counter counts to awlen+1. The burst always ends on the counted final beat. A wlast value that mismatches the counter (early 1 or missing on the final beat) sets the error flag -> after the final beat, W_RESP.
  - W_RESP (bvalid=1, bresp=2'b10 if error flag else 2'b00): bready -> W_IDLE.
  - W data arriving before AW is back-pressured (wready=0 outside W_DATA).
- Read FSM:
  - R_IDLE (arready=1): AR handshake latches fields, loads the latency counter -> R_WAIT, or R_DATA directly if READ_LATENCY=0.
  - R_WAIT: counts READ_LATENCY cycles -> R_DATA.
  - First rvalid appears at handshake cycle + 1 + READ_LATENCY.
  - R_DATA (rvalid=1): rdata is combinational from the array at the current address; 0 with rresp=2'b10 when out of range or reserved burst, else rresp=2'b00. rlast=1 on beat arlen+1. rdata/rresp/rlast are held stable while rready=0. The final beat handshake -> R_IDLE.
- Read/write collision: a read beat on the word written in the same cycle returns old data; the following beat returns new data.
- awlen=0 / arlen=0: single-beat transactions. awlen=255 is supported, and the counters are 9 bits wide.

Test Plan:
- Reset, then AW addr=0x40 len=3 INCR size=3 with wdata 1..4, strb=0xFF, wlast on beat 4 -> one B with bresp=0. Then AR same params, READ_LATENCY=2 -> rvalid 3 cycles after AR handshake, data 1,2,3,4, rlast on beat 4 only.
- WRAP: write 1..4 at 0x10 len=3 size=3, then read INCR from 0x00 len=3 -> data 3,4,1,2.
- Strobe and backpressure: write 0xFFFF_FFFF_FFFF_FFFF then 0 with strb=0x0F to 0x0; read with rready toggling 1/0 -> data 0xFFFF_FFFF_0000_0000, stable while rready=0.
- Errors: write to 0x2000 (MEM_WORDS=1024) -> bresp=2'b10, memory unchanged. Write len=1 with wlast on beat 1 -> 2 beats accepted, bresp=2'b10. Read at 0x2000 -> rdata=0, rresp=2'b10.
- Concurrency and reset: simultaneous AW/AR to one word -> independent completion, read sees old value in the collision cycle. Assert aresetn low mid-read-burst -> rvalid=0 immediately; arready=1 one cycle after release; memory retains data.
